// File: rtl/gigatron_io_if.sv
// Bus between the Gigatron core and its IO unit: core OUT/ACC and ready in,
// extended output, controller IN bus and controller strobes out.
interface gigatron_io_if #(
  parameter int WIDTH    = 8,
  parameter int NUM_PADS = 1,
  parameter int PSEL_W   = 3
);
  logic                i_ready;
  logic [WIDTH-1:0]    i_out;
  logic [WIDTH-1:0]    i_acc;
  logic [NUM_PADS-1:0] i_pad_data;
  logic [PSEL_W-1:0]   i_pad_sel;
  logic [WIDTH-1:0]    o_xout;
  logic [WIDTH-1:0]    o_in;
  logic                o_in_valid;
  logic                o_pad_latch;
  logic                o_pad_clock;

  modport slave (
    input  i_ready, i_out, i_acc, i_pad_data, i_pad_sel,
    output o_xout, o_in, o_in_valid, o_pad_latch, o_pad_clock
  );

  modport master (
    output i_ready, i_out, i_acc, i_pad_data, i_pad_sel,
    input  o_xout, o_in, o_in_valid, o_pad_latch, o_pad_clock
  );
endinterface

// File: rtl/gigatron_io_unit.sv
// Gigatron peripheral unit: sync-edge detection on OUT, XOUT latch from ACC on hsync,
// and serial readout of NUM_PADS controllers (latch = vsync, clock = hsync).
module gigatron_io_unit #(
  parameter int WIDTH           = 8,
  parameter int HSYNC_BIT       = 6,
  parameter int VSYNC_BIT       = 7,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int NUM_PADS        = 1,
  parameter int PSEL_W          = 3
) (
  input  logic           i_clock,
  input  logic           i_reset,
  gigatron_io_if.slave   io
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

  logic [WIDTH-1:0] r_prev_out;
  logic [WIDTH-1:0] r_xout;
  logic [CNT_W-1:0] r_cnt;
  logic             r_in_valid;
  logic             r_pad_latch;
  logic             r_pad_clock;
  logic [WIDTH-1:0] r_shift [NUM_PADS];
  logic [WIDTH-1:0] r_pad   [NUM_PADS];

  logic             w_h_active;
  logic             w_v_active;
  logic             w_h_was_active;
  logic             w_v_was_active;
  logic             w_h_edge;
  logic             w_v_edge;
  logic             w_shift_en;
  logic             w_frame_done;
  logic [WIDTH-1:0] w_in_mux;

  // Edge of interest is the end of the pulse, whatever the polarity.
  assign w_h_active     = (SYNC_ACTIVE_LOW != 0) ? ~io.i_out[HSYNC_BIT]    : io.i_out[HSYNC_BIT];
  assign w_v_active     = (SYNC_ACTIVE_LOW != 0) ? ~io.i_out[VSYNC_BIT]    : io.i_out[VSYNC_BIT];
  assign w_h_was_active = (SYNC_ACTIVE_LOW != 0) ? ~r_prev_out[HSYNC_BIT]  : r_prev_out[HSYNC_BIT];
  assign w_v_was_active = (SYNC_ACTIVE_LOW != 0) ? ~r_prev_out[VSYNC_BIT]  : r_prev_out[VSYNC_BIT];
  assign w_h_edge       = w_h_was_active & ~w_h_active;
  assign w_v_edge       = w_v_was_active & ~w_v_active;

  assign w_shift_en   = io.i_ready & w_h_edge & ~w_v_edge & (r_cnt < CNT_FULL);
  assign w_frame_done = w_shift_en & (r_cnt == CNT_FULL - CNT_W'(1));

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_prev_out  <= '0;
      r_xout      <= '0;
      r_cnt       <= CNT_FULL;
      r_pad_latch <= 1'b0;
      r_pad_clock <= 1'b0;
    end else if (io.i_ready) begin
      r_prev_out  <= io.i_out;
      r_pad_latch <= w_v_active;
      r_pad_clock <= w_h_active;
      if (w_h_edge) begin
        r_xout <= io.i_acc;
      end
      if (w_v_edge) begin
        r_cnt <= '0;
      end else if (w_shift_en) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Valid is a pulse, so it is refreshed every cycle rather than held by i_ready.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_in_valid <= 1'b0;
    end else begin
      r_in_valid <= w_frame_done;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_PADS; gi++) begin : g_pad
      always_ff @(posedge i_clock) begin
        if (i_reset) begin
          r_shift[gi] <= '1;
          r_pad[gi]   <= '1;
        end else if (w_shift_en) begin
          r_shift[gi] <= {r_shift[gi][WIDTH-2:0], io.i_pad_data[gi]};
          if (w_frame_done) begin
            r_pad[gi] <= {r_shift[gi][WIDTH-2:0], io.i_pad_data[gi]};
          end
        end
      end
    end
  endgenerate

  // Unpopulated pad slots read as "no button pressed".
  always_comb begin
    w_in_mux = '1;
    for (int p = 0; p < NUM_PADS; p++) begin
      if (io.i_pad_sel == PSEL_W'(p)) begin
        w_in_mux = r_pad[p];
      end
    end
  end

  assign io.o_xout      = r_xout;
  assign io.o_in        = w_in_mux;
  assign io.o_in_valid  = r_in_valid;
  assign io.o_pad_latch = r_pad_latch;
  assign io.o_pad_clock = r_pad_clock;
endmodule

// File: tb/tb_gigatron_io_unit.sv
// Self-checking bench for gigatron_io_unit with two pads; a frame-level model
// collects sampled controller bits per vsync frame and assembles them MSB first.
module tb_gigatron_io_unit;
  localparam int NP = 2;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  gigatron_io_if #(.WIDTH(8), .NUM_PADS(NP), .PSEL_W(3)) bus ();

  gigatron_io_unit #(
    .WIDTH(8), .HSYNC_BIT(6), .VSYNC_BIT(7), .SYNC_ACTIVE_LOW(1),
    .NUM_PADS(NP), .PSEL_W(3)
  ) dut (
    .i_clock (clk),
    .i_reset (rst),
    .io      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]      m_prev;
  logic [7:0]      m_xout;
  logic [7:0]      m_pad [NP];
  logic [NP-1:0]   m_q [$];
  bit              m_reading;
  logic            m_valid;
  logic            m_latch;
  logic            m_clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    bit h, v;
    logic [7:0] val;
    if (rst) begin
      m_prev = 8'h00; m_xout = 8'h00;
      for (int p = 0; p < NP; p++) m_pad[p] = 8'hFF;
      m_q.delete(); m_reading = 0;
      m_valid = 0; m_latch = 0; m_clock = 0;
    end else if (!bus.i_ready) begin
      m_valid = 0;
    end else begin
      h = !m_prev[6] && bus.i_out[6];
      v = !m_prev[7] && bus.i_out[7];
      m_valid = 0;
      if (h) m_xout = bus.i_acc;
      if (v) begin
        m_q.delete();
        m_reading = 1;
      end else if (h && m_reading) begin
        m_q.push_back(bus.i_pad_data);
        if (m_q.size() == 8) begin
          for (int p = 0; p < NP; p++) begin
            val = 8'h00;
            for (int i = 0; i < 8; i++) if (m_q[i][p]) val[7-i] = 1'b1;
            m_pad[p] = val;
          end
          m_valid = 1;
          m_reading = 0;
        end
      end
      m_latch = !bus.i_out[7];
      m_clock = !bus.i_out[6];
      m_prev  = bus.i_out;
    end
  endtask

  task automatic tick();
    logic [7:0] exp_in;
    @(posedge clk);
    model_update();
    #1;
    exp_in = (bus.i_pad_sel < NP) ? m_pad[bus.i_pad_sel] : 8'hFF;
    chk("xout",  bus.o_xout, m_xout);
    chk("in",    bus.o_in, exp_in);
    chk("valid", {7'd0, bus.o_in_valid}, {7'd0, m_valid});
    chk("latch", {7'd0, bus.o_pad_latch}, {7'd0, m_latch});
    chk("clock", {7'd0, bus.o_pad_clock}, {7'd0, m_clock});
    $display("t=%0t out=%02h acc=%02h data=%b sel=%0d rdy=%b -> xout=%02h in=%02h valid=%b",
             $time, bus.i_out, bus.i_acc, bus.i_pad_data, bus.i_pad_sel, bus.i_ready,
             bus.o_xout, bus.o_in, bus.o_in_valid);
  endtask

  // hsync pulse, then its end edge with the given ACC and controller data
  task automatic do_h(input logic [7:0] acc, input logic [NP-1:0] data);
    bus.i_out = {2'b10, 6'($urandom)};
    bus.i_acc = 8'($urandom);
    tick();
    bus.i_out      = {2'b11, 6'($urandom)};
    bus.i_acc      = acc;
    bus.i_pad_data = data;
    tick();
  endtask

  task automatic do_v();
    bus.i_out = {2'b01, 6'($urandom)};
    tick();
    bus.i_out = {2'b11, 6'($urandom)};
    tick();
  endtask

  logic [7:0] pat;
  logic [7:0] xsave;

  initial begin
    compared = 0; mismatched = 0;
    rst = 1'b1;
    bus.i_ready = 1'b1; bus.i_out = 8'h00; bus.i_acc = 8'h00;
    bus.i_pad_data = '0; bus.i_pad_sel = 3'd0;

    // Reset
    tick(); tick();
    chk("rst_xout", bus.o_xout, 8'h00);
    chk("rst_in", bus.o_in, 8'hFF);
    rst = 1'b0;

    // XOUT latch on hsync rise
    bus.i_acc = 8'h5A; bus.i_out = 8'h00; tick();
    bus.i_out = 8'h40; tick();
    chk("xout_5a", bus.o_xout, 8'h5A);
    bus.i_acc = 8'h11; tick();
    chk("xout_hold", bus.o_xout, 8'h5A);

    // Directed pad read: pad0 1,0,1,0,0,1,1,0 ; pad1 all zero
    pat = 8'hA6;
    do_v();
    for (int i = 0; i < 8; i++) begin
      pat = 8'hA6;
      do_h(8'($urandom), {1'b0, pat[7-i]});
    end
    chk("valid_pulse", {7'd0, bus.o_in_valid}, 8'h01);
    chk("pad0_a6", bus.o_in, 8'hA6);
    bus.i_pad_sel = 3'd1; tick();
    chk("valid_clear", {7'd0, bus.o_in_valid}, 8'h00);
    chk("pad1_00", bus.o_in, 8'h00);
    bus.i_pad_sel = 3'd3; #1;
    chk("sel3_ff", bus.o_in, 8'hFF);
    bus.i_pad_sel = 3'd0;

    // Extra hsync edges after a full frame shift nothing
    do_h(8'h77, 2'b11);
    chk("sat_pad0", bus.o_in, 8'hA6);

    // Abort mid-read, then a full read
    do_v();
    for (int i = 0; i < 5; i++) do_h(8'($urandom), 2'b00);
    do_v();
    chk("abort_keep", bus.o_in, 8'hA6);
    for (int i = 0; i < 8; i++) do_h(8'($urandom), 2'($urandom));

    // Freeze: hsync rise while not ready
    bus.i_out = 8'h80; tick();
    xsave = bus.o_xout;
    bus.i_ready = 1'b0; bus.i_acc = 8'h33; bus.i_out = 8'hC0; tick(); tick();
    chk("freeze_xout", bus.o_xout, xsave);
    bus.i_ready = 1'b1; tick();
    chk("resume_xout", bus.o_xout, 8'h33);

    // Reset mid-read
    do_v();
    for (int i = 0; i < 3; i++) do_h(8'($urandom), 2'b00);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_mid_in", bus.o_in, 8'hFF);
    chk("rst_mid_xout", bus.o_xout, 8'h00);

    // Random frames with occasional stalls, aborts and pad selection changes
    for (int f = 0; f < 12; f++) begin
      int n;
      do_v();
      n = $urandom_range(4, 10);
      for (int i = 0; i < n; i++) begin
        bus.i_pad_sel = 3'($urandom_range(0, 3));
        bus.i_ready   = ($urandom_range(0, 5) != 0);
        do_h(8'($urandom), 2'($urandom));
        bus.i_ready = 1'b1;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
